// File: rtl/mc_alu_pkg.sv
// Shared opcode constants and FSM state encoding for the multi-cycle ALU.
package mc_alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mc_alu_addsub.sv
// Combinational adder/subtractor: sum, carry (borrow on subtract), signed overflow, SLT/SLTU bits.
module mc_alu_addsub #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  sub_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  carry_o,
  output logic                  overflow_o,
  output logic                  slt_o,
  output logic                  sltu_o
);

  localparam int unsigned MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] b_eff;
  logic                  c_msb;

  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    {c_msb, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub_i};
    overflow_o = (a_i[MSB] == b_eff[MSB]) && (sum_o[MSB] != a_i[MSB]);
    // Subtract: no carry out of A + ~B + 1 means A < B unsigned.
    carry_o    = sub_i ? ~c_msb : c_msb;
    slt_o      = sum_o[MSB] ^ overflow_o;
    sltu_o     = ~c_msb;
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU with valid/ready handshakes, iterative shifts and, with MC_ALU_MUL_EN
// defined, an iterative shift-add multiplier.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  localparam int unsigned CNT_W = SHAMT_W + 1;
  localparam int unsigned MSB   = DATA_WIDTH - 1;

  state_t                state_q;
  logic [3:0]            op_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] sh_q, res_q;
  logic                  ov_q, co_q, zero_q, valid_q;

  logic                  accept, is_shift, last;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] res_d, sh_d;
  logic                  ov_d, co_d;
  logic [DATA_WIDTH-1:0] as_a, as_b, as_sum;
  logic                  as_sub, as_cry, as_ovf, as_slt, as_sltu;

`ifdef MC_ALU_MUL_EN
  logic [DATA_WIDTH-1:0] acc_q, mcand_q, mul_hi, acc_d, lo_d;
  logic                  mul_cry;
`endif

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign shamt     = B[SHAMT_W-1:0];
  assign is_shift  = (ALUop == OP_SLL) || (ALUop == OP_SRL) || (ALUop == OP_SRA);
  assign last      = (cnt_q == CNT_W'(1));
  assign out_valid = valid_q;
  assign Result    = res_q;
  assign Overflow  = ov_q;
  assign CarryOut  = co_q;
  assign Zero      = zero_q;

  // The adder serves the issuing op, except during multiply where it accumulates.
  always_comb begin
    as_a   = A;
    as_b   = B;
    as_sub = (ALUop == OP_SUB) || (ALUop == OP_SLT) || (ALUop == OP_SLTU);
`ifdef MC_ALU_MUL_EN
    if (state_q == BUSY) begin
      as_a   = acc_q;
      as_b   = mcand_q;
      as_sub = 1'b0;
    end
`endif
  end

  mc_alu_addsub #(.DATA_WIDTH(DATA_WIDTH)) u_addsub (
    .a_i        (as_a),
    .b_i        (as_b),
    .sub_i      (as_sub),
    .sum_o      (as_sum),
    .carry_o    (as_cry),
    .overflow_o (as_ovf),
    .slt_o      (as_slt),
    .sltu_o     (as_sltu)
  );

  always_comb begin
    res_d = '0;
    ov_d  = 1'b0;
    co_d  = 1'b0;
    case (ALUop)
      OP_AND:                 res_d = A & B;
      OP_OR:                  res_d = A | B;
      OP_XOR:                 res_d = A ^ B;
      OP_NOR:                 res_d = ~(A | B);
      OP_ADD, OP_SUB: begin
        res_d = as_sum;
        ov_d  = as_ovf;
        co_d  = as_cry;
      end
      OP_SLT:                 res_d = {{(DATA_WIDTH-1){1'b0}}, as_slt};
      OP_SLTU:                res_d = {{(DATA_WIDTH-1){1'b0}}, as_sltu};
      OP_SLL, OP_SRL, OP_SRA: res_d = A;
      default:                res_d = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  sh_d = {sh_q[MSB-1:0], 1'b0};
      OP_SRL:  sh_d = {1'b0, sh_q[MSB:1]};
      OP_SRA:  sh_d = {sh_q[MSB], sh_q[MSB:1]};
      default: sh_d = sh_q;
    endcase
  end

`ifdef MC_ALU_MUL_EN
  // {acc, lo} holds the partial product; lo also shifts out the multiplier bits.
  always_comb begin
    mul_cry = sh_q[0] ? as_cry : 1'b0;
    mul_hi  = sh_q[0] ? as_sum : acc_q;
    acc_d   = {mul_cry, mul_hi[MSB:1]};
    lo_d    = {mul_hi[0], sh_q[MSB:1]};
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q    <= OP_AND;
      cnt_q   <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
      co_q    <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
`ifdef MC_ALU_MUL_EN
      acc_q   <= '0;
      mcand_q <= '0;
`endif
    end else begin
      case (state_q)
        BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
`ifdef MC_ALU_MUL_EN
          if (op_q == OP_MUL) begin
            acc_q <= acc_d;
            sh_q  <= lo_d;
            if (last) begin
              res_q   <= lo_d;
              ov_q    <= 1'b0;
              co_q    <= |acc_d;
              zero_q  <= (lo_d == '0);
              state_q <= DONE;
              valid_q <= 1'b1;
            end
          end else
`endif
          begin
            sh_q <= sh_d;
            if (last) begin
              res_q   <= sh_d;
              ov_q    <= 1'b0;
              co_q    <= 1'b0;
              zero_q  <= (sh_d == '0);
              state_q <= DONE;
              valid_q <= 1'b1;
            end
          end
        end
        default: begin
          if (accept) begin
            op_q <= ALUop;
            if (is_shift && (shamt != '0)) begin
              sh_q    <= A;
              cnt_q   <= CNT_W'(shamt);
              state_q <= BUSY;
              valid_q <= 1'b0;
            end
`ifdef MC_ALU_MUL_EN
            else if (ALUop == OP_MUL) begin
              acc_q   <= '0;
              mcand_q <= A;
              sh_q    <= B;
              cnt_q   <= CNT_W'(DATA_WIDTH);
              state_q <= BUSY;
              valid_q <= 1'b0;
            end
`endif
            else begin
              res_q   <= res_d;
              ov_q    <= ov_d;
              co_q    <= co_d;
              zero_q  <= (res_d == '0);
              state_q <= DONE;
              valid_q <= 1'b1;
            end
          end else if ((state_q == DONE) && out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Directed self-checking bench for mc_alu (DATA_WIDTH=32); MUL expectations follow MC_ALU_MUL_EN.
module tb_mc_alu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, Result;
  logic [3:0]  ALUop;
  logic        Overflow, CarryOut, Zero;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  mc_alu #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUop     (ALUop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Overflow  (Overflow),
    .CarryOut  (CarryOut),
    .Zero      (Zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE with out_ready=1; lat counts negedges until out_valid.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int l);
    @(negedge clk);
    ALUop = op; A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; A = 32'hDEADBEEF; B = 32'h00000013;
    l = 1;
    while (out_valid !== 1'b1 && l < 60) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic exp_out(input string tag, input logic [31:0] r, input logic ov,
                         input logic co, input logic z, input int l, input int le);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_res"},   Result, r);
    chk({tag, "_ovf"},   {31'b0, Overflow}, {31'b0, ov});
    chk({tag, "_cry"},   {31'b0, CarryOut}, {31'b0, co});
    chk({tag, "_zero"},  {31'b0, Zero}, {31'b0, z});
    chk({tag, "_lat"},   l, le);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; ALUop = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_res",   Result, 32'd0);
    chk("rst_zero",  {31'b0, Zero}, 32'd1);
    chk("rst_ovf",   {31'b0, Overflow}, 32'd0);
    chk("rst_cry",   {31'b0, CarryOut}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);

    do_op(4'b0010, 32'h7FFFFFFF, 32'h00000001, lat);
    exp_out("add_ovf", 32'h80000000, 1'b1, 1'b0, 1'b0, lat, 1);
    do_op(4'b0010, 32'hFFFFFFFF, 32'h00000001, lat);
    exp_out("add_cry", 32'h00000000, 1'b0, 1'b1, 1'b1, lat, 1);
    do_op(4'b0110, 32'h00000005, 32'h00000005, lat);
    exp_out("sub_eq", 32'h00000000, 1'b0, 1'b0, 1'b1, lat, 1);
    do_op(4'b0110, 32'h00000001, 32'h00000002, lat);
    exp_out("sub_brw", 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, lat, 1);
    do_op(4'b0110, 32'h80000000, 32'h00000001, lat);
    exp_out("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, lat, 1);
    do_op(4'b0011, 32'h00000001, 32'hFFFFFFFF, lat);
    exp_out("sltu", 32'h00000001, 1'b0, 1'b0, 1'b0, lat, 1);
    do_op(4'b0111, 32'hFFFFFFFF, 32'h00000001, lat);
    exp_out("slt_t", 32'h00000001, 1'b0, 1'b0, 1'b0, lat, 1);
    do_op(4'b0111, 32'h00000001, 32'hFFFFFFFF, lat);
    exp_out("slt_f", 32'h00000000, 1'b0, 1'b0, 1'b1, lat, 1);
    do_op(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    exp_out("and", 32'hF000F000, 1'b0, 1'b0, 1'b0, lat, 1);
    do_op(4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    exp_out("or", 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, lat, 1);
    do_op(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    exp_out("xor", 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, lat, 1);
    do_op(4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    exp_out("nor", 32'h000F000F, 1'b0, 1'b0, 1'b0, lat, 1);
    do_op(4'b1100, 32'h12345678, 32'h9ABCDEF0, lat);
    exp_out("illegal", 32'h00000000, 1'b0, 1'b0, 1'b1, lat, 1);

    do_op(4'b1010, 32'h80000000, 32'h00000004, lat);
    exp_out("sra4", 32'hF8000000, 1'b0, 1'b0, 1'b0, lat, 5);
    do_op(4'b1000, 32'h12345678, 32'h00000000, lat);
    exp_out("sll0", 32'h12345678, 1'b0, 1'b0, 1'b0, lat, 1);
    do_op(4'b1000, 32'h00000001, 32'hFFFFFFFF, lat);
    exp_out("sll31", 32'h80000000, 1'b0, 1'b0, 1'b0, lat, 32);
    do_op(4'b1001, 32'h80000000, 32'h00000021, lat);
    exp_out("srl1", 32'h40000000, 1'b0, 1'b0, 1'b0, lat, 2);

`ifdef MC_ALU_MUL_EN
    do_op(4'b1011, 32'h00010000, 32'h00010000, lat);
    exp_out("mul_hi", 32'h00000000, 1'b0, 1'b1, 1'b1, lat, 33);
    do_op(4'b1011, 32'h00000003, 32'h00000005, lat);
    exp_out("mul_lo", 32'h0000000F, 1'b0, 1'b0, 1'b0, lat, 33);
`else
    do_op(4'b1011, 32'h00010000, 32'h00010000, lat);
    exp_out("mul_off", 32'h00000000, 1'b0, 1'b0, 1'b1, lat, 1);
`endif

    // Backpressure: hold ADD result while the next op waits on in_valid.
    @(negedge clk);
    out_ready = 1'b0; ALUop = 4'b0010; A = 32'd2; B = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    A = 32'd10; B = 32'd20;
    chk("bp_valid0", {31'b0, out_valid}, 32'd1);
    chk("bp_res0", Result, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_res", Result, 32'd5);
      chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_b2b_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_b2b_res", Result, 32'd30);
    @(negedge clk);
    chk("bp_drain_valid", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a long SRL.
    @(negedge clk);
    ALUop = 4'b1001; A = 32'h80000000; B = 32'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("srl_busy_valid", {31'b0, out_valid}, 32'd0);
    resetn = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_res", Result, 32'd0);
    chk("mrst_zero", {31'b0, Zero}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("mrst_ready", {31'b0, in_ready}, 32'd1);
    repeat (20) @(negedge clk);
    chk("mrst_idle_valid", {31'b0, out_valid}, 32'd0);
    do_op(4'b0010, 32'd1, 32'd1, lat);
    exp_out("post_rst", 32'd2, 1'b0, 1'b0, 1'b0, lat, 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
